pipe_stage_hs: RTL and testbench

//  Parametrised pipeline stage register with valid/ready handshake, flush, and optional 2-entry skid buffer.

---
 rtl/pipe_stage_hs_pkg.sv | 24 ++
 rtl/pipe_stage_hs.sv | 122 ++++++++++++
 tb/tb_pipe_stage_hs.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_hs_pkg.sv
// Purpose: shared definitions for handshaked pipeline stages.
//   - state encoding for stages that hold up to two entries
//   - hs_fire(): transfer condition of a valid/ready pair
// Handshake rule used by every stage that imports this package:
//   A transfer ("fire") happens on a rising clock edge where valid and ready
//   are both high. A producer holding valid high keeps its payload stable
//   until it fires. A consumer may change ready at any time.
package pipe_stage_hs_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_ONE   = ST_ONE,
        S_TWO   = ST_TWO
    } hs_state_e;

    function automatic logic hs_fire(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/pipe_stage_hs.sv
// Purpose: pipeline stage register with valid/ready handshake, synchronous
// flush and an optional second (skid) entry for full throughput with a
// registered in_ready.
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   default_data in   bubble payload loaded on flush or drain-to-empty
//   flush        in   discard all held entries on the next edge
//   in_valid     in   upstream payload valid
//   in_ready     out  stage can accept (registered when SKID_EN=1)
//   in_data      in   upstream payload
//   out_valid    out  out_data holds a real entry
//   out_ready    in   downstream accepts
//   out_data     out  head entry, registered
//   occupancy    out  entries held (0..2); equals the state encoding
module pipe_stage_hs
    import pipe_stage_hs_pkg::*;
#(
    parameter int unsigned            DataWidth = 32,
    parameter bit                     SKID_EN   = 1'b1,
    parameter logic [DataWidth-1:0]   RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DataWidth-1:0] default_data,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DataWidth-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DataWidth-1:0] out_data,
    output logic [1:0]           occupancy
);

    hs_state_e            state_q, state_d;
    logic [DataWidth-1:0] main_q, main_d;
    logic [DataWidth-1:0] skid_q, skid_d;
    logic                 in_fire, out_fire;

    assign out_valid = (state_q != S_EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;  // encoding doubles as the entry count

    assign in_fire  = hs_fire(in_valid, in_ready);
    assign out_fire = hs_fire(out_valid, out_ready);

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Flush wins over any same-cycle accept; the skid entry is simply
            // forgotten since the state no longer points at it.
            state_d = S_EMPTY;
            main_d  = default_data;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        state_d = S_ONE;
                        main_d  = in_data;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        // Only reachable with SKID_EN=1: without a skid entry
                        // in_ready already requires out_ready when full.
                        state_d = S_TWO;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = S_EMPTY;
                        main_d  = default_data;
                    end
                end
                S_TWO: begin
                    if (out_fire) begin
                        state_d = S_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                    main_d  = default_data;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    generate
        if (SKID_EN) begin : g_skid
            // Registered ready: computed from the next state so it is valid
            // in the same cycle the state register updates.
            logic in_ready_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_d != S_TWO);
                end
            end
            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: one instance with the skid entry and one without,
// both driven by the same inputs. Each instance has a queue-based reference
// model (a bounded FIFO plus the last bubble value).
module tb_pipe_stage_hs;

    localparam logic [31:0] RV = 32'h0BAD_F00D;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] default_data;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready0, out_valid0, in_ready1, out_valid1;
    logic [31:0] out_data0, out_data1;
    logic [1:0]  occ0, occ1;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] bub0 = RV;
    logic [31:0] bub1 = RV;

    pipe_stage_hs #(.DataWidth(32), .SKID_EN(1'b1), .RESET_VAL(RV)) dut_skid (
        .clk(clk), .rst(rst), .default_data(default_data), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .occupancy(occ0)
    );

    pipe_stage_hs #(.DataWidth(32), .SKID_EN(1'b0), .RESET_VAL(RV)) dut_noskid (
        .clk(clk), .rst(rst), .default_data(default_data), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .occupancy(occ1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("skid.out_valid", 32'(out_valid0), 32'(q0.size() > 0));
        chk("skid.out_data",  out_data0, (q0.size() > 0) ? q0[0] : bub0);
        chk("skid.occupancy", 32'(occ0), 32'(q0.size()));
        chk("skid.in_ready",  32'(in_ready0), 32'(q0.size() < 2));
        chk("noskid.out_valid", 32'(out_valid1), 32'(q1.size() > 0));
        chk("noskid.out_data",  out_data1, (q1.size() > 0) ? q1[0] : bub1);
        chk("noskid.occupancy", 32'(occ1), 32'(q1.size()));
        chk("noskid.in_ready",  32'(in_ready1), 32'((q1.size() == 0) || out_ready));
    endtask

    // Called just after a negedge with inputs already driven; ends on the
    // following negedge with both models advanced by one clock edge.
    task automatic step();
        logic if0, if1, of0, of1;
        #1 check_all();
        if0 = in_valid && (q0.size() < 2);
        if1 = in_valid && ((q1.size() == 0) || out_ready);
        of0 = (q0.size() > 0) && out_ready;
        of1 = (q1.size() > 0) && out_ready;
        @(posedge clk);
        if (flush) begin
            q0.delete(); bub0 = default_data;
            q1.delete(); bub1 = default_data;
        end else begin
            if (of0) void'(q0.pop_front());
            if (if0) q0.push_back(in_data);
            if (of0 && q0.size() == 0) bub0 = default_data;
            if (of1) void'(q1.pop_front());
            if (if1) q1.push_back(in_data);
            if (of1 && q1.size() == 0) bub1 = default_data;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] vals[3];
        int          idx;
        logic        acc;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; default_data = 32'h0000_0013;
        #2 rst = 1'b0;
        @(negedge clk);
        #1 check_all();
        rst = 1'b1;
        step();
        step();

        // Reset asserted mid-stream with a held input.
        in_valid = 1'b1; in_data = 32'h11; step();
        in_data = 32'h22; step();
        in_data = 32'hDEAD_BEEF;
        #2 rst = 1'b0;
        #1;
        chk("t1.skid.out_valid", 32'(out_valid0), 32'd0);
        chk("t1.skid.out_data",  out_data0, RV);
        chk("t1.skid.occupancy", 32'(occ0), 32'd0);
        chk("t1.noskid.out_valid", 32'(out_valid1), 32'd0);
        chk("t1.noskid.out_data",  out_data1, RV);
        q0.delete(); q1.delete(); bub0 = RV; bub1 = RV;
        @(negedge clk);
        rst = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        chk("t1.after_release.data",  out_data0, 32'hDEAD_BEEF);
        chk("t1.after_release.valid", 32'(out_valid0), 32'd1);
        step();

        // Back-to-back streaming.
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1; in_data = 32'(i); step();
        end
        in_valid = 1'b0;
        step(); step();

        // Back-pressure with an upstream that holds data until accepted.
        vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
        idx = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = vals[idx];
            acc = (q0.size() < 2);
            step();
            if (acc) idx++;
        end
        #1;
        chk("t3.occupancy", 32'(occ0), 32'd2);
        chk("t3.in_ready",  32'(in_ready0), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 10 && idx < 3; i++) begin
            in_valid = 1'b1; in_data = vals[idx];
            acc = (q0.size() < 2);
            step();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        step(); step(); step();

        // Flush with two held entries and a same-cycle input.
        out_ready = 1'b0; default_data = 32'h0000_0013;
        in_valid = 1'b1; in_data = 32'hA; step();
        in_data = 32'hB; step();
        flush = 1'b1; in_data = 32'hC; step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("t4.out_valid", 32'(out_valid0), 32'd0);
        chk("t4.out_data",  out_data0, 32'h0000_0013);
        chk("t4.occupancy", 32'(occ0), 32'd0);
        step();

        // Drain to empty loads the bubble.
        in_valid = 1'b1; in_data = 32'h55; step();
        in_valid = 1'b0; out_ready = 1'b1; default_data = 32'h0000_0077;
        step();
        #1;
        chk("t5.out_valid", 32'(out_valid0), 32'd0);
        chk("t5.out_data",  out_data0, 32'h0000_0077);
        step();

        // Combinational ready of the single-entry variant.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h66; step();
        in_data = 32'h67;
        #1 chk("t6.in_ready_blocked", 32'(in_ready1), 32'd0);
        out_ready = 1'b1;
        #1 chk("t6.in_ready_open", 32'(in_ready1), 32'd1);
        step();
        in_valid = 1'b0;
        #1;
        chk("t6.replaced_data", out_data1, 32'h67);
        chk("t6.occupancy",     32'(occ1), 32'd1);
        step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) default_data = $urandom;
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step(); step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
